// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin burst arbiter sharing one RAM port among NREQ requesters
module ram_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     rq_ren,
  input  logic [NREQ-1:0]     rq_wen,
  input  logic [NREQ*32-1:0]  rq_addr,
  input  logic [NREQ*32-1:0]  rq_store,
  output logic [NREQ-1:0]     rq_wait,
  output logic [NREQ*32-1:0]  rq_load,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate,
  output logic [IW-1:0]       gnt_id,
  output logic                gnt_vld,
  output logic                err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] req_any;
  logic [IW-1:0]   pick;
  logic            found;
  logic            own_ren, own_wen;

  assign req_any = rq_ren | rq_wen;
  assign own_ren = rq_ren[owner_q];
  assign own_wen = rq_wen[owner_q];

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_any[(int'(rr_q) + i) % NREQ]) begin
        pick  = IW'((int'(rr_q) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    rq_wait  = '1;
    rq_load  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    gnt_id   = '0;
    gnt_vld  = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        gnt_vld  = 1'b1;
        gnt_id   = owner_q;
        ramaddr  = rq_addr[32*int'(owner_q) +: 32];
        ramstore = rq_store[32*int'(owner_q) +: 32];
        rq_load[32*int'(owner_q) +: 32] = ramload;
        if (!(own_ren || own_wen)) begin
          // Owner withdrew: end the burst without touching the RAM.
          state_d = GAP;
        end else begin
          ramWEN = own_wen;
          ramREN = own_ren & ~own_wen;
          rq_wait[owner_q] = (ramstate != RS_ACCESS);
          if (ramstate == RS_ERROR) begin
            err     = 1'b1;
            state_d = GAP;
          end else if (ramstate == RS_ACCESS) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(BURST - 1)) state_d = GAP;
          end
        end
      end

      GAP: begin
        rr_d    = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (0,1 = core0/core1 icache; 2,3 = core0/core1 dcache).
REQ-002 Parameter: BURST, 2, words per granted transfer (block size).
REQ-003 Ports: CLK  in  1  clock, all state updates on rising edge.
REQ-004 Ports: nRST  in  1  reset; asynchronous, active-low.
REQ-005 Ports: rq_ren  in  NREQ  per-requester read request.
REQ-006 Ports: rq_wen  in  NREQ  per-requester write request.
REQ-007 Ports: rq_addr  in  NREQ x 32  per-requester word address.
REQ-008 Ports: rq_store  in  NREQ x 32  per-requester write data.
REQ-009 Ports: rq_wait  out  NREQ  per-requester wait; 0 = current word completed this cycle.
REQ-010 Ports: rq_load  out  NREQ x 32  per-requester read data, valid when rq_wait bit is 0.
REQ-011 Ports: ramREN, ramWEN  out  1 each  RAM read/write enables.
REQ-012 Ports: ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-013 Ports: ramload  in  32  RAM read data.
REQ-014 Ports: ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-015 Ports: gnt_id  out  log2(NREQ)  index of current owner; gnt_vld  out  1  owner valid.
REQ-016 Ports: err  out  1  one-cycle pulse on RAM ERROR during an owned transfer.

Function
REQ-017 FSM states: IDLE, XFER, GAP.
- IDLE: if any rq_ren|rq_wen bit set, select owner by round-robin starting at pointer rr_ptr; latch owner, clear word counter, -> XFER next cycle. No RAM enables driven in IDLE.
REQ-018 XFER: drive ramaddr=rq_addr[owner], ramstore=rq_store[owner]; ramWEN=rq_wen[owner]; ramREN=rq_ren[owner] & ~rq_wen[owner] (write wins over read from same requester).
REQ-019 XFER: rq_wait[owner] = (ramstate != ACCESS); rq_load[owner] = ramload; all non-owner rq_wait = 1, all non-owner rq_load = 0.
REQ-020 XFER word count: on ramstate==ACCESS increment counter; when counter == BURST-1 and ACCESS -> GAP.
REQ-021 XFER abort: owner drops both rq_ren and rq_wen -> GAP same edge, no RAM enables that cycle.
REQ-022 XFER error: ramstate==ERROR -> err=1 for that cycle, owner rq_wait stays 1, -> GAP.
REQ-023 GAP: one cycle, no RAM enables, all rq_wait=1; rr_ptr <= (owner+1) mod NREQ; -> IDLE.
REQ-024 Round-robin: owner is the first asserted requester at or after rr_ptr, wrapping from NREQ-1 to 0; any persistently requesting requester is granted within NREQ transfers.
REQ-025 Grant latency: request rising in IDLE -> RAM enables asserted the following cycle; minimum 2 idle cycles (GAP, IDLE) between transfers.
REQ-026 Ownership is never preempted mid-burst; requests from other requesters during XFER are ignored until IDLE.
REQ-027 gnt_vld=1 and gnt_id=owner only in XFER; otherwise gnt_vld=0, gnt_id=0.
REQ-028 Requester address changes mid-burst are passed through unmodified; arbiter does not generate addresses.

Reset
REQ-029 nRST low asynchronously forces: state=IDLE, rr_ptr=0, owner=0, counter=0.
REQ-030 During and after reset until first grant: ramREN=ramWEN=0, ramaddr=ramstore=0, rq_wait=all 1, rq_load=all 0, gnt_vld=0, gnt_id=0, err=0.
REQ-031 Reset asserted mid-XFER aborts transfer immediately; no RAM enable survives the reset assertion.

Verification
REQ-032 Single read: rq_ren=4'b0001, addr 0x100/0x104, ramstate ACCESS after 2 BUSY cycles per word -> ramREN=1 in XFER, rq_wait[0] low exactly on the two ACCESS cycles, rq_load[0]=ramload, then GAP, rr_ptr=1.
REQ-033 Round-robin: all four rq_ren held high from reset -> grant order 0,1,2,3,0, each 2 words, 2-cycle gap between.
REQ-034 Read+write same requester: rq_ren[2]=rq_wen[2]=1, store 0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-035 Abort: owner 3 drops requests after word 0 -> no second RAM access, GAP, next grant from 0.
REQ-036 Error: ramstate=ERROR in XFER -> err pulse 1 cycle, rq_wait[owner]=1, FSM returns to IDLE via GAP.
REQ-037 Reset mid-XFER: nRST low while ramWEN=1 -> ramWEN=0 within same cycle, all rq_wait=1, gnt_vld=0.
